// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants and the 16-bit coordinate type.
// Default timing is standard 640x480 at a 25 MHz pixel clock derived from 100 MHz.
package vga_timing_pkg;

   typedef logic [15:0] coord_t;

   localparam int DEF_CLK_DIV   = 4;
   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FP      = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BP      = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FP      = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BP      = 33;

   localparam int H_TOTAL      = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL      = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
   localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

   function automatic coord_t wrap_inc(input coord_t value, input coord_t last);
      return (value == last) ? '0 : value + 16'd1;
   endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_clk_div.sv
// System-clock to pixel-rate divider. o_tick marks the clk whose edge wraps the
// divider; o_pix_en is the same event registered, so it is high for that one clk afterwards.
module pixel_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick,
   output logic o_pix_en
);

   localparam int              DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]   L_DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] r_div;
   logic          r_pix_en;
   logic          w_tick;

   assign w_tick   = (r_div == L_DIV_LAST);
   assign o_tick   = w_tick;
   assign o_pix_en = r_pix_en;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div    <= '0;
         r_pix_en <= 1'b0;
      end else begin
         r_div    <= w_tick ? '0 : r_div + DW'(1);
         r_pix_en <= w_tick;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel divider, column/row counters and registered sync/visible/strobe flags.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit frame counter port (frame_count).
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef VGA_FRAME_COUNT_EN
   output logic [7:0]  frame_count,
`endif
   output logic        pix_en,
   output logic [15:0] column,
   output logic [15:0] row,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        line_start,
   output logic        frame_start
);

   localparam int     L_H_TOTAL_I = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int     L_V_TOTAL_I = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam coord_t L_H_LAST    = coord_t'(L_H_TOTAL_I - 1);
   localparam coord_t L_V_LAST    = coord_t'(L_V_TOTAL_I - 1);
   localparam coord_t L_H_VIS     = coord_t'(H_VISIBLE);
   localparam coord_t L_V_VIS     = coord_t'(V_VISIBLE);
   localparam coord_t L_HS_START  = coord_t'(H_VISIBLE + H_FP);
   localparam coord_t L_HS_END    = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam coord_t L_VS_START  = coord_t'(V_VISIBLE + V_FP);
   localparam coord_t L_VS_END    = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end
   if (L_H_TOTAL_I >= 65536 || L_V_TOTAL_I >= 65536) begin : g_bad_totals
      $error("vga_timing_gen: H/V totals must fit in 16 bits");
   end

   logic   w_tick;
   coord_t r_column, r_row;
   logic   r_hsync, r_vsync, r_video_on, r_line_start, r_frame_start;
   coord_t w_col_nxt, w_row_nxt;
   logic   w_hsync_nxt, w_vsync_nxt, w_video_on_nxt, w_line_start_nxt, w_frame_start_nxt;

   pixel_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_pixel_clk_div (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .o_tick   (w_tick),
      .o_pix_en (pix_en)
   );

   // Flags are decoded from the next counter values so they land on the same edge as the counters.
   always_comb begin
      w_col_nxt         = wrap_inc(r_column, L_H_LAST);
      w_row_nxt         = r_row;
      if (r_column == L_H_LAST) begin
         w_row_nxt = wrap_inc(r_row, L_V_LAST);
      end
      w_hsync_nxt       = !((w_col_nxt >= L_HS_START) && (w_col_nxt <= L_HS_END));
      w_vsync_nxt       = !((w_row_nxt >= L_VS_START) && (w_row_nxt <= L_VS_END));
      w_video_on_nxt    = (w_col_nxt < L_H_VIS) && (w_row_nxt < L_V_VIS);
      w_line_start_nxt  = (w_col_nxt == '0);
      w_frame_start_nxt = (w_col_nxt == '0) && (w_row_nxt == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_column      <= L_H_LAST;
         r_row         <= L_V_LAST;
         r_hsync       <= 1'b1;
         r_vsync       <= 1'b1;
         r_video_on    <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (w_tick) begin
         r_column      <= w_col_nxt;
         r_row         <= w_row_nxt;
         r_hsync       <= w_hsync_nxt;
         r_vsync       <= w_vsync_nxt;
         r_video_on    <= w_video_on_nxt;
         r_line_start  <= w_line_start_nxt;
         r_frame_start <= w_frame_start_nxt;
      end else begin
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] r_frame_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_count <= 8'd0;
      end else if (w_tick && w_frame_start_nxt) begin
         r_frame_count <= r_frame_count + 8'd1;
      end
   end

   assign frame_count = r_frame_count;
`endif

   assign column      = r_column;
   assign row         = r_row;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign video_on    = r_video_on;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance for divider/line checks and a
// shrunken-timing instance (10x8 raster, CLK_DIV=2) for frame, reset and frame-count checks.
module tb_vga_timing_gen;

`ifdef VGA_FRAME_COUNT_EN
   localparam int NFR = 257;
`else
   localparam int NFR = 3;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        d_pix_en, d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start;
   logic [15:0] d_column, d_row;
   logic        s_pix_en, s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
   logic [15:0] s_column, s_row;
`ifdef VGA_FRAME_COUNT_EN
   logic [7:0]  d_frame_count, s_frame_count;
`endif

   vga_timing_gen u_dut_def (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef VGA_FRAME_COUNT_EN
      .frame_count (d_frame_count),
`endif
      .pix_en      (d_pix_en),
      .column      (d_column),
      .row         (d_row),
      .hsync       (d_hsync),
      .vsync       (d_vsync),
      .video_on    (d_video_on),
      .line_start  (d_line_start),
      .frame_start (d_frame_start)
   );

   // visible 6x4, hsync columns 7..8, vsync rows 5..6, total 10x8
   vga_timing_gen #(
      .CLK_DIV(2), .H_VISIBLE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) u_dut_small (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef VGA_FRAME_COUNT_EN
      .frame_count (s_frame_count),
`endif
      .pix_en      (s_pix_en),
      .column      (s_column),
      .row         (s_row),
      .hsync       (s_hsync),
      .vsync       (s_vsync),
      .video_on    (s_video_on),
      .line_start  (s_line_start),
      .frame_start (s_frame_start)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   logic [3:0]  d_pe_seq, s_pe_seq;
   int          npe, nhs, nls, hs_min, hs_max, cyc;
   logic [1:0]  vo_a, vo_b, vo_c, vo_d;
   bit          reached;
   int          nfs, pe_since, fr_pe, wrap_row, prev_row, nvs, vs_min, vs_max, nls_f;
   int          n_hold, n_orphan, n_fs_no_ls;
   logic [15:0] hold_col, hold_row;
   logic [7:0]  fc1, fc255, fc256, fc257;

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_val("rst_col",      d_column, 799);
      chk_val("rst_row",      d_row, 524);
      chk_val("rst_hsync",    d_hsync, 1);
      chk_val("rst_vsync",    d_vsync, 1);
      chk_val("rst_video_on", d_video_on, 0);
      chk_val("rst_strobes",  {d_pix_en, d_line_start, d_frame_start}, 0);
      chk_val("rst_s_col",    s_column, 9);
      chk_val("rst_s_row",    s_row, 7);
`ifdef VGA_FRAME_COUNT_EN
      chk_val("rst_fcount",   d_frame_count, 0);
`endif

      // release on a falling edge, then sample pix_en after each of the next four rising edges
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         d_pe_seq[k] = d_pix_en;
         s_pe_seq[k] = s_pix_en;
      end
      chk_val("first_pe_div4", d_pe_seq, 4'b1000);
      chk_val("first_pe_div2", s_pe_seq, 4'b1010);
      chk_val("first_col",     d_column, 0);
      chk_val("first_row",     d_row, 0);
      chk_val("first_fs",      d_frame_start, 1);
      chk_val("first_ls",      d_line_start, 1);
      chk_val("first_vo",      d_video_on, 1);
      chk_val("first_hsync",   d_hsync, 1);
      chk_val("s_second_col",  s_column, 1);
      chk_val("s_second_ls",   s_line_start, 0);
`ifdef VGA_FRAME_COUNT_EN
      chk_val("first_fcount",  d_frame_count, 1);
`endif

      // one full default line: columns 1..799 then back to 0
      npe = 0; nhs = 0; nls = 0; hs_min = 99999; hs_max = -1; cyc = 0;
      vo_a = 2'd2; vo_b = 2'd2;
      while (npe < 800 && cyc < 800 * 4 + 40) begin
         @(negedge clk);
         cyc++;
         if (d_pix_en) begin
            npe++;
            if (!d_hsync) begin
               nhs++;
               if (int'(d_column) < hs_min) hs_min = int'(d_column);
               if (int'(d_column) > hs_max) hs_max = int'(d_column);
            end
            if (d_line_start) nls++;
            if (d_column == 16'd639) vo_a = {1'b0, d_video_on};
            if (d_column == 16'd640) vo_b = {1'b0, d_video_on};
         end
      end
      chk_val("line_pe_count",  npe, 800);
      chk_val("hsync_low_cnt",  nhs, 96);
      chk_val("hsync_first",    hs_min, 656);
      chk_val("hsync_last",     hs_max, 751);
      chk_val("line_start_cnt", nls, 1);
      chk_val("line_end_col",   d_column, 0);
      chk_val("line_end_row",   d_row, 1);
      chk_val("vo_639_0",       vo_a, 1);
      chk_val("vo_640_0",       vo_b, 0);

      // reset mid-frame on the small raster at (col 3, row 2)
      reached = 1'b0; cyc = 0;
      while (!reached && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (s_pix_en && s_column == 16'd3 && s_row == 16'd2) reached = 1'b1;
      end
      chk_val("mid_reach", reached, 1);
      #2 rst_n = 1'b0;
      #1;
      chk_val("mid_rst_col",   s_column, 9);
      chk_val("mid_rst_row",   s_row, 7);
      chk_val("mid_rst_sync",  {s_hsync, s_vsync}, 2'b11);
      chk_val("mid_rst_vo",    s_video_on, 0);
      chk_val("mid_rst_strb",  {s_pix_en, s_line_start, s_frame_start}, 0);
      chk_val("mid_rst_dcol",  d_column, 799);
      @(negedge clk);
      rst_n = 1'b1;

      // frames on the small raster
      nfs = 0; pe_since = 0; fr_pe = -1; wrap_row = -1; prev_row = -1;
      nvs = 0; vs_min = 99999; vs_max = -1; nls_f = 0;
      n_hold = 0; n_orphan = 0; n_fs_no_ls = 0;
      vo_a = 2'd2; vo_b = 2'd2; vo_c = 2'd2; vo_d = 2'd2;
      fc1 = 8'hAA; fc255 = 8'hAA; fc256 = 8'hAA; fc257 = 8'hAA;
      hold_col = s_column; hold_row = s_row; cyc = 0;
      while (nfs < NFR && cyc < NFR * 160 + 400) begin
         @(negedge clk);
         cyc++;
         if (!s_pix_en) begin
            if (s_line_start || s_frame_start) n_orphan++;
            if (s_column != hold_col || s_row != hold_row) n_hold++;
         end else begin
            if (s_frame_start) begin
               nfs++;
               if (nfs == 2) begin
                  fr_pe    = pe_since;
                  wrap_row = prev_row;
               end
`ifdef VGA_FRAME_COUNT_EN
               if (nfs == 1)   fc1   = s_frame_count;
               if (nfs == 255) fc255 = s_frame_count;
               if (nfs == 256) fc256 = s_frame_count;
               if (nfs == 257) fc257 = s_frame_count;
`endif
               if (!s_line_start) n_fs_no_ls++;
               pe_since = 0;
            end
            pe_since++;
            if (nfs == 1) begin
               if (!s_vsync) begin
                  nvs++;
                  if (int'(s_row) < vs_min) vs_min = int'(s_row);
                  if (int'(s_row) > vs_max) vs_max = int'(s_row);
               end
               if (s_line_start) nls_f++;
               if (s_column == 16'd5 && s_row == 16'd3) vo_a = {1'b0, s_video_on};
               if (s_column == 16'd6 && s_row == 16'd0) vo_b = {1'b0, s_video_on};
               if (s_column == 16'd0 && s_row == 16'd4) vo_c = {1'b0, s_video_on};
               if (s_column == 16'd9 && s_row == 16'd7) vo_d = {1'b0, s_video_on};
            end
            prev_row = int'(s_row);
         end
         hold_col = s_column;
         hold_row = s_row;
      end
      chk_val("frames_seen",    nfs, NFR);
      chk_val("frame_pe_count", fr_pe, 80);
      chk_val("row_wrap_from",  wrap_row, 7);
      chk_val("vsync_low_cnt",  nvs, 20);
      chk_val("vsync_first",    vs_min, 5);
      chk_val("vsync_last",     vs_max, 6);
      chk_val("frame_ls_cnt",   nls_f, 8);
      chk_val("vo_last_vis",    vo_a, 1);
      chk_val("vo_col_past",    vo_b, 0);
      chk_val("vo_row_past",    vo_c, 0);
      chk_val("vo_frame_end",   vo_d, 0);
      chk_val("hold_between",   n_hold, 0);
      chk_val("orphan_strobe",  n_orphan, 0);
      chk_val("fs_without_ls",  n_fs_no_ls, 0);
`ifdef VGA_FRAME_COUNT_EN
      chk_val("fcount_1",       fc1, 1);
      chk_val("fcount_255",     fc255, 255);
      chk_val("fcount_256",     fc256, 0);
      chk_val("fcount_257",     fc257, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
